// File: rtl/ks_note_sequencer.sv
// Note sequencer for the Karplus-Strong string core: steps through a (period, duration)
// table, plucks the string through a valid/ready handshake, and forwards manual controls when idle.
module ks_note_sequencer #(
  parameter int NUM_STEPS     = 8,
  parameter int STEP_W        = 3,
  parameter int PERIOD_W      = 8,
  parameter int DUR_W         = 8,
  parameter int KS_MAX_LENGTH = 48,
  parameter int KS_MIN_LENGTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic                cfg_we,
  input  logic [STEP_W-1:0]   cfg_addr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUR_W-1:0]    cfg_dur,
  input  logic                seq_en,
  input  logic                seq_loop,
  input  logic [STEP_W:0]     seq_len,
  input  logic [PERIOD_W-1:0] man_period,
  input  logic                man_pluck,
  input  logic                ks_ready,
  output logic [PERIOD_W-1:0] ks_period,
  output logic                ks_pluck,
  output logic                seq_active,
  output logic [STEP_W-1:0]   step_idx,
  output logic                seq_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLUCK, S_HOLD, S_NEXT} state_t;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUR_W-1:0]    dur;
  } note_t;

  state_t              state, state_nxt;
  note_t               tbl [NUM_STEPS];
  note_t               entry, cur;
  logic                cur_end;
  logic [DUR_W-1:0]    cnt;
  logic                hold_first;
  logic [STEP_W:0]     eff_len;
  logic                has_more, tick_done, restart;
  logic [PERIOD_W-1:0] period_nxt;
  logic                pluck_nxt, done_nxt;
  logic [STEP_W-1:0]   idx_nxt;

  function automatic logic [PERIOD_W-1:0] clamp(input logic [PERIOD_W-1:0] p);
    if (p > PERIOD_W'(KS_MAX_LENGTH))                   return PERIOD_W'(KS_MAX_LENGTH);
    else if (p != '0 && p < PERIOD_W'(KS_MIN_LENGTH))   return PERIOD_W'(KS_MIN_LENGTH);
    else                                                return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= '{period: cfg_period, dur: cfg_dur};
    end
  end

  assign entry     = tbl[step_idx];
  assign eff_len   = (seq_len == '0) ? (STEP_W+1)'(NUM_STEPS) : seq_len;
  assign has_more  = ((STEP_W+1)'(step_idx) + (STEP_W+1)'(1)) < eff_len;
  // The tick landing in the HOLD entry cycle is deliberately not counted
  assign tick_done = sample_tick && !hold_first && ((cnt + DUR_W'(1)) == cur.dur);
  // An end marker at step 0 would reload itself forever, so looping stops there
  assign restart   = seq_loop && !(cur_end && step_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (seq_en && !(ks_pluck && !ks_ready)) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!seq_en)                   state_nxt = S_IDLE;
        else if (entry.dur == '0)      state_nxt = S_NEXT;
        else if (entry.period == '0)   state_nxt = S_HOLD;
        else                           state_nxt = S_PLUCK;
      end
      S_PLUCK: if (ks_ready) state_nxt = seq_en ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (!seq_en)        state_nxt = S_IDLE;
        else if (tick_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (seq_en && ((has_more && !cur_end) || restart)) state_nxt = S_LOAD;
        else                                               state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    period_nxt = ks_period;
    pluck_nxt  = ks_pluck;
    idx_nxt    = step_idx;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        period_nxt = clamp(man_period);
        if (state_nxt == S_LOAD) begin
          pluck_nxt = 1'b0;
          idx_nxt   = '0;
        end else begin
          pluck_nxt = (ks_pluck && !ks_ready) || man_pluck;
        end
      end
      S_LOAD: if (state_nxt == S_PLUCK) begin
        period_nxt = clamp(entry.period);
        pluck_nxt  = 1'b1;
      end
      S_PLUCK: if (ks_ready) pluck_nxt = 1'b0;
      S_NEXT: begin
        if (state_nxt == S_LOAD)
          idx_nxt = (has_more && !cur_end) ? step_idx + STEP_W'(1) : '0;
        else
          done_nxt = seq_en && !seq_loop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_period  <= PERIOD_W'(KS_MAX_LENGTH);
      ks_pluck   <= 1'b0;
      seq_active <= 1'b0;
      step_idx   <= '0;
      seq_done   <= 1'b0;
      cur        <= '0;
      cur_end    <= 1'b0;
      cnt        <= '0;
      hold_first <= 1'b0;
    end else begin
      ks_period  <= period_nxt;
      ks_pluck   <= pluck_nxt;
      seq_active <= (state_nxt != S_IDLE);
      step_idx   <= idx_nxt;
      seq_done   <= done_nxt;
      if (state == S_LOAD) begin
        cur     <= entry;
        cur_end <= (entry.dur == '0);
      end
      hold_first <= (state_nxt == S_HOLD) && (state != S_HOLD);
      if (state != S_HOLD)                   cnt <= '0;
      else if (sample_tick && !hold_first)   cnt <= cnt + DUR_W'(1);
    end
  end

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer: manual pluck, table playback, end marker,
// looping with live table edit, seq_en drop during a stalled pluck, async reset.
module tb_ks_note_sequencer;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sample_tick = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_period = '0, cfg_dur = '0;
  logic       seq_en = 1'b0, seq_loop = 1'b0;
  logic [3:0] seq_len = '0;
  logic [7:0] man_period = '0;
  logic       man_pluck = 1'b0, ks_ready = 1'b1;
  logic [7:0] ks_period;
  logic       ks_pluck, seq_active, seq_done;
  logic [2:0] step_idx;

  int pass_cnt = 0, total_cnt = 0;
  int n_xfer = 0, n_done = 0;
  int x0, d0;

  ks_note_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period), .cfg_dur(cfg_dur),
    .seq_en(seq_en), .seq_loop(seq_loop), .seq_len(seq_len),
    .man_period(man_period), .man_pluck(man_pluck), .ks_ready(ks_ready),
    .ks_period(ks_period), .ks_pluck(ks_pluck), .seq_active(seq_active),
    .step_idx(step_idx), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ks_pluck && ks_ready) n_xfer++;
    if (seq_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_period = p; cfg_dur = d;
    step();
    cfg_we = 1'b0;
  endtask

  // one frame pulse followed by two quiet cycles
  task automatic tick();
    sample_tick = 1'b1; step();
    sample_tick = 1'b0; step(); step();
  endtask

  // waits for a pluck, checks it, then moves past the transfer and the HOLD entry cycle
  task automatic wait_pluck(input string tag, input logic [7:0] p, input logic [2:0] idx);
    for (int i = 0; i < 20 && !ks_pluck; i++) step();
    chk({tag, "_pluck"}, ks_pluck, 1);
    chk({tag, "_period"}, ks_period, p);
    chk({tag, "_idx"}, step_idx, idx);
    step(); step();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !seq_done; i++) step();
    chk(tag, seq_done, 1);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_pluck", ks_pluck, 0);
    chk("rst_active", seq_active, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_period", ks_period, 48);
    rst_n = 1'b1;
    step();

    // manual pluck held by a stalled core, period clamps to 48
    man_period = 8'd100; ks_ready = 1'b0; man_pluck = 1'b1;
    step();
    man_pluck = 1'b0;
    chk("man_period", ks_period, 48);
    for (int i = 0; i < 5; i++) begin
      chk("man_pluck_hi", ks_pluck, 1);
      step();
    end
    ks_ready = 1'b1;
    chk("man_pluck_hi6", ks_pluck, 1);
    step();
    chk("man_pluck_drop", ks_pluck, 0);

    // four-step table with a rest at step 2
    wr(3'd0, 8'd30, 8'd2); wr(3'd1, 8'd20, 8'd1); wr(3'd2, 8'd0, 8'd1); wr(3'd3, 8'd40, 8'd3);
    seq_len = 4'd4; seq_loop = 1'b0; x0 = n_xfer; d0 = n_done;
    seq_en = 1'b1;
    wait_pluck("s0", 8'd30, 3'd0);
    tick();
    chk("s0_wait_pluck", ks_pluck, 0);
    chk("s0_wait_idx", step_idx, 0);
    tick();
    wait_pluck("s1", 8'd20, 3'd1);
    tick();
    chk("rest_idx", step_idx, 2);
    chk("rest_pluck", ks_pluck, 0);
    chk("rest_period", ks_period, 20);
    tick();                                  // lands in the HOLD entry cycle: not counted
    chk("rest_entry_tick_idx", step_idx, 2);
    chk("rest_entry_tick_pluck", ks_pluck, 0);
    tick();
    wait_pluck("s3", 8'd40, 3'd3);
    tick(); tick();
    chk("s3_active", seq_active, 1);
    chk("s3_done_early", seq_done, 0);
    sample_tick = 1'b1; step();
    sample_tick = 1'b0;
    chk("s3_done_next", seq_done, 0);
    step();
    chk("s3_done", seq_done, 1);
    chk("s3_idle", seq_active, 0);
    seq_en = 1'b0;
    step();
    chk("s3_done_pulse", seq_done, 0);
    chk("seq_xfers", n_xfer - x0, 3);
    chk("seq_dones", n_done - d0, 1);

    // end marker at step 1
    wr(3'd1, 8'd20, 8'd0);
    x0 = n_xfer; seq_en = 1'b1;
    wait_pluck("em0", 8'd30, 3'd0);
    tick(); tick();
    wait_done("em_done");
    seq_en = 1'b0;
    chk("em_idx", step_idx, 1);
    chk("em_xfers", n_xfer - x0, 1);
    step();

    // looping two steps, entry 0 rewritten mid-note, manual pluck ignored
    wr(3'd1, 8'd20, 8'd1);
    seq_len = 4'd2; seq_loop = 1'b1; d0 = n_done;
    seq_en = 1'b1;
    wait_pluck("lp0", 8'd30, 3'd0);
    wr(3'd0, 8'd25, 8'd2);
    man_pluck = 1'b1; step(); man_pluck = 1'b0;
    chk("man_ignored", ks_pluck, 0);
    tick(); tick();
    wait_pluck("lp1", 8'd20, 3'd1);
    tick();
    wait_pluck("lp2", 8'd25, 3'd0);
    tick(); tick();
    wait_pluck("lp3", 8'd20, 3'd1);
    seq_en = 1'b0;
    step();
    chk("lp_stop_active", seq_active, 0);
    chk("lp_no_done", n_done - d0, 0);

    // seq_en dropped during a stalled pluck; period 1 clamps to 2
    wr(3'd0, 8'd1, 8'd1);
    seq_loop = 1'b0; ks_ready = 1'b0; seq_en = 1'b1;
    step(); step();
    chk("stall_pluck", ks_pluck, 1);
    chk("stall_period", ks_period, 2);
    seq_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", ks_pluck, 1);
    end
    ks_ready = 1'b1;
    step();
    chk("stall_drop", ks_pluck, 0);
    chk("stall_idle", seq_active, 0);
    step();
    chk("idle_clamp_hi", ks_period, 48);
    man_period = 8'd1; step();
    chk("idle_clamp_lo", ks_period, 2);
    man_period = 8'd0; step();
    chk("idle_zero", ks_period, 0);

    // asynchronous reset mid-note clears outputs and the table
    wr(3'd0, 8'd40, 8'd5);
    seq_en = 1'b1;
    wait_pluck("ar", 8'd40, 3'd0);
    rst_n = 1'b0; #1;
    chk("ar_active", seq_active, 0);
    chk("ar_period", ks_period, 48);
    chk("ar_pluck", ks_pluck, 0);
    #1 rst_n = 1'b1;
    x0 = n_xfer;
    wait_done("ar_empty_done");
    seq_en = 1'b0;
    chk("ar_empty_xfers", n_xfer - x0, 0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
